regfile_scoreboard: RTL and testbench

- Sequential replacement for comparator-based RAW hazard detection in the non-forwarding 5-stage pipeline.
- Keeps a per-register countdown of in-flight writes and stalls the ID stage while a source register still has an outstanding write.
- Drives the PC/IF-ID enables and the ID/EX bubble, and undoes the scoreboard entry of an instruction squashed in EX by a taken branch/jump.
- Sits beside the decoder; the ID/EX register is its only consumer of the flush.

---
 rtl/regfile_scoreboard_if.sv | 43 ++++
 rtl/regfile_scoreboard.sv | 102 ++++++++++
 tb/tb_regfile_scoreboard.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// ID-stage hazard bundle between the decoder side and the scoreboard.
// master drives the ID/EX status, slave returns stall/enable decisions.
interface regfile_scoreboard_if #(
   parameter int NREG  = 32,
   parameter int PERFW = 16
);
   logic             i_id_valid;
   logic [31:0]      i_id_instr;
   logic             i_id_rd_wren;
   logic             i_kill_ex;
   logic             o_stall;
   logic             o_flush_ex;
   logic             o_enable_pc;
   logic             o_enable_id;
   logic [NREG-1:0]  o_busy_mask;
   logic [PERFW-1:0] o_stall_cycles;

   modport master (
      output i_id_valid,
      output i_id_instr,
      output i_id_rd_wren,
      output i_kill_ex,
      input  o_stall,
      input  o_flush_ex,
      input  o_enable_pc,
      input  o_enable_id,
      input  o_busy_mask,
      input  o_stall_cycles
   );

   modport slave (
      input  i_id_valid,
      input  i_id_instr,
      input  i_id_rd_wren,
      input  i_kill_ex,
      output o_stall,
      output o_flush_ex,
      output o_enable_pc,
      output o_enable_id,
      output o_busy_mask,
      output o_stall_cycles
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Regfile scoreboard: per-register countdown of in-flight writes.
// Stalls ID on RAW hazards and undoes a write squashed in EX.
module regfile_scoreboard #(
   parameter int NREG  = 32,
   parameter int DEPTH = 3,
   parameter int CNTW  = 2,
   parameter int PERFW = 16
) (
   input logic                 i_clk,
   input logic                 i_rst_n,
   regfile_scoreboard_if.slave sb
);
   logic [CNTW-1:0]  cnt     [NREG];
   logic [CNTW-1:0]  cnt_nxt [NREG];
   logic             sh_v;
   logic [4:0]       sh_rd;
   logic [CNTW-1:0]  sh_prev;
   logic [PERFW-1:0] perf;

   logic [4:0] rs1, rs2, rd, opc;
   logic       use1, use2;
   logic       hazard, stall, issue;

   assign rs1 = sb.i_id_instr[19:15];
   assign rs2 = sb.i_id_instr[24:20];
   assign rd  = sb.i_id_instr[11:7];
   assign opc = sb.i_id_instr[6:2];

   always_comb begin
      use1 = 1'b0;
      use2 = 1'b0;
      unique case (opc)
         5'b11001, 5'b00100, 5'b00000:
            use1 = 1'b1;
         5'b01100, 5'b01000, 5'b11000: begin
            use1 = 1'b1;
            use2 = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      hazard = sb.i_id_valid &
               ((use1 & (rs1 != '0) & (cnt[rs1] != '0)) |
                (use2 & (rs2 != '0) & (cnt[rs2] != '0)));
      stall  = hazard & ~sb.i_kill_ex;
      issue  = sb.i_id_valid & ~stall & ~sb.i_kill_ex &
               sb.i_id_rd_wren & (rd != '0);
   end

   // Later assignments win: issue beats kill restore beats decrement.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         cnt_nxt[r] = (cnt[r] != '0) ? cnt[r] - CNTW'(1) : '0;
      end
      if (sb.i_kill_ex && sh_v) begin
         cnt_nxt[sh_rd] = (sh_prev > CNTW'(1)) ?
                          sh_prev - CNTW'(2) : '0;
      end
      if (issue) begin
         cnt_nxt[rd] = CNTW'(DEPTH);
      end
      cnt_nxt[0] = '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            cnt[r] <= '0;
         end
         sh_v    <= 1'b0;
         sh_rd   <= '0;
         sh_prev <= '0;
         perf    <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            cnt[r] <= cnt_nxt[r];
         end
         sh_v <= issue;
         if (issue) begin
            sh_rd   <= rd;
            sh_prev <= cnt[rd];
         end
         if (stall && !(&perf)) begin
            perf <= perf + PERFW'(1);
         end
      end
   end

   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         sb.o_busy_mask[r] = (cnt[r] != '0);
      end
   end

   assign sb.o_stall        = stall;
   assign sb.o_flush_ex     = stall;
   assign sb.o_enable_pc    = ~stall;
   assign sb.o_enable_id    = ~stall;
   assign sb.o_stall_cycles = perf;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: in-flight write list model feeding
// an expectation queue, plus directed stall-count checks.
module tb_regfile_scoreboard;
   localparam int NREG  = 32;
   localparam int DEPTH = 3;
   localparam int CNTW  = 2;
   localparam int PERFW = 16;

   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_AUI = 7'b0010111;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_OP  = 7'b0110011;
   localparam logic [6:0] OP_ST  = 7'b0100011;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   regfile_scoreboard_if #(.NREG(NREG), .PERFW(PERFW)) sb ();

   regfile_scoreboard #(
      .NREG(NREG), .DEPTH(DEPTH), .CNTW(CNTW), .PERFW(PERFW)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .sb(sb)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic             stall;
      logic [NREG-1:0]  busy;
      logic [PERFW-1:0] perf;
   } exp_t;

   typedef struct {
      int rd;
      int rem;
   } ent_t;

   exp_t             expq[$];
   ent_t             ents[$];
   bit               last_iss;
   logic [PERFW-1:0] m_perf;

   function automatic logic [NREG-1:0] m_mask();
      logic [NREG-1:0] m;
      m = '0;
      foreach (ents[i]) if (ents[i].rem > 0) m[ents[i].rd] = 1'b1;
      return m;
   endfunction

   function automatic logic [31:0] mk(input logic [6:0] op,
                                      input int rd,
                                      input int rs1,
                                      input int rs2);
      return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), op};
   endfunction

   function automatic bit m_hazard(input logic [31:0] ins);
      logic [4:0]      o;
      logic [NREG-1:0] m;
      bit              u1, u2;
      o  = ins[6:2];
      u1 = 0;
      u2 = 0;
      if (o inside {5'b11001, 5'b00100, 5'b00000}) u1 = 1;
      if (o inside {5'b01100, 5'b01000, 5'b11000}) begin
         u1 = 1;
         u2 = 1;
      end
      m = m_mask();
      return (u1 && ins[19:15] != 0 && m[ins[19:15]]) ||
             (u2 && ins[24:20] != 0 && m[ins[24:20]]);
   endfunction

   task automatic m_reset();
      ents.delete();
      last_iss = 0;
      m_perf   = '0;
   endtask

   // One ID cycle; st returns the DUT stall sampled mid-cycle.
   task automatic cyc(input bit v, input logic [31:0] ins,
                      input bit w, input bit k, output bit st);
      bit   hz, mst, iss;
      exp_t e;
      ent_t keep[$];
      ent_t ne;
      sb.i_id_valid   = v;
      sb.i_id_instr   = ins;
      sb.i_id_rd_wren = w;
      sb.i_kill_ex    = k;
      hz  = v && m_hazard(ins);
      mst = hz && !k;
      iss = v && !mst && !k && w && ins[11:7] != 0;
      e.stall = mst;
      e.busy  = m_mask();
      e.perf  = m_perf;
      expq.push_back(e);
      @(negedge clk);
      st = sb.o_stall;
      @(posedge clk);
      foreach (ents[i]) ents[i].rem--;
      if (k && last_iss) void'(ents.pop_back());
      foreach (ents[i]) if (ents[i].rem > 0) keep.push_back(ents[i]);
      ents = keep;
      if (iss) begin
         ne.rd  = int'(ins[11:7]);
         ne.rem = DEPTH;
         ents.push_back(ne);
      end
      last_iss = iss;
      if (mst && m_perf != '1) m_perf++;
      #1;
   endtask

   task automatic idle(input int c);
      bit st;
      repeat (c) cyc(0, 32'd0, 0, 0, st);
   endtask

   // Hold an instruction in ID until it issues; n = stalled cycles.
   task automatic hold(input logic [31:0] ins, input bit w,
                       output int n);
      bit st;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1, ins, w, 0, st);
         if (!st) break;
         n++;
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         chk("stall", 64'(sb.o_stall), 64'(e.stall));
         chk("flush", 64'(sb.o_flush_ex), 64'(e.stall));
         chk("en_pc", 64'(sb.o_enable_pc), 64'(!e.stall));
         chk("en_id", 64'(sb.o_enable_id), 64'(!e.stall));
         chk("busy", 64'(sb.o_busy_mask), 64'(e.busy));
         chk("perf", 64'(sb.o_stall_cycles), 64'(e.perf));
      end
   end

   initial begin
      int n;
      int sat;
      bit st;
      m_reset();
      sb.i_id_valid   = 0;
      sb.i_id_instr   = '0;
      sb.i_id_rd_wren = 0;
      sb.i_kill_ex    = 0;
      #1;
      chk("rst_stall", 64'(sb.o_stall), 0);
      chk("rst_flush", 64'(sb.o_flush_ex), 0);
      chk("rst_en_pc", 64'(sb.o_enable_pc), 1);
      chk("rst_en_id", 64'(sb.o_enable_id), 1);
      chk("rst_busy", 64'(sb.o_busy_mask), 0);
      chk("rst_perf", 64'(sb.o_stall_cycles), 0);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      idle(1);

      cyc(1, mk(OP_OP, 5, 1, 2), 1, 0, st);
      hold(mk(OP_OP, 6, 5, 1), 0, n);
      chk("b2b_stall", 64'(n), 3);
      chk("b2b_perf", 64'(sb.o_stall_cycles), 3);
      idle(4);

      for (int d = 2; d <= 4; d++) begin
         cyc(1, mk(OP_OP, 7, 1, 2), 1, 0, st);
         idle(d - 1);
         hold(mk(OP_OP, 8, 7, 1), 0, n);
         chk($sformatf("dist%0d", d), 64'(n), 64'(4 - d));
         idle(4);
      end

      cyc(1, mk(OP_OP, 3, 1, 2), 1, 0, st);
      hold(mk(OP_LUI, 0, 3, 3), 0, n);
      chk("lui", 64'(n), 0);
      hold(mk(OP_AUI, 0, 3, 3), 0, n);
      chk("auipc", 64'(n), 0);
      hold(mk(OP_JAL, 0, 3, 3), 0, n);
      chk("jal", 64'(n), 0);
      idle(4);

      cyc(1, mk(OP_OP, 0, 1, 2), 1, 0, st);
      hold(mk(OP_OP, 1, 0, 0), 0, n);
      chk("x0_src", 64'(n), 0);
      chk("x0_busy", 64'(sb.o_busy_mask[0]), 0);
      idle(4);

      cyc(1, mk(OP_OP, 4, 1, 2), 1, 0, st);
      hold(mk(OP_IMM, 0, 1, 4), 0, n);
      chk("opimm_rs2", 64'(n), 0);
      hold(mk(OP_ST, 0, 1, 4), 0, n);
      chk("store_rs2", 64'(n), 2);
      idle(4);

      cyc(1, mk(OP_OP, 9, 1, 2), 1, 0, st);
      cyc(1, mk(OP_OP, 9, 1, 2), 1, 0, st);
      cyc(1, mk(OP_OP, 10, 1, 2), 1, 1, st);
      chk("kill_busy9", 64'(sb.o_busy_mask[9]), 1);
      chk("kill_busy10", 64'(sb.o_busy_mask[10]), 0);
      hold(mk(OP_OP, 11, 9, 1), 0, n);
      chk("kill_restore", 64'(n), 1);
      idle(4);

      cyc(1, mk(OP_OP, 9, 1, 2), 1, 0, st);
      cyc(0, 32'd0, 0, 1, st);
      chk("kill_single", 64'(sb.o_busy_mask[9]), 0);
      hold(mk(OP_OP, 11, 9, 1), 0, n);
      chk("kill_single_st", 64'(n), 0);
      idle(4);

      cyc(1, mk(OP_OP, 12, 1, 2), 1, 0, st);
      idle(1);
      cyc(1, mk(OP_OP, 13, 12, 1), 1, 1, st);
      chk("kill_hz_stall", 64'(st), 0);
      chk("kill_hz_noiss", 64'(sb.o_busy_mask[13]), 0);
      chk("kill_hz_keep", 64'(sb.o_busy_mask[12]), 1);
      cyc(0, 32'd0, 0, 1, st);
      idle(4);

      cyc(1, mk(OP_OP, 5, 1, 2), 1, 0, st);
      sb.i_id_valid   = 1;
      sb.i_id_instr   = mk(OP_OP, 6, 5, 1);
      sb.i_id_rd_wren = 0;
      sb.i_kill_ex    = 0;
      #2;
      chk("pre_rst_stall", 64'(sb.o_stall), 1);
      rst_n = 0;
      #1;
      chk("arst_stall", 64'(sb.o_stall), 0);
      chk("arst_busy", 64'(sb.o_busy_mask), 0);
      chk("arst_perf", 64'(sb.o_stall_cycles), 0);
      m_reset();
      sb.i_id_valid = 0;
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      idle(1);

      sat = 0;
      while (m_perf != '1 && sat < 90000) begin
         cyc(1, mk(OP_OP, 5, 5, 1), 1, 0, st);
         sat++;
      end
      repeat (8) cyc(1, mk(OP_OP, 5, 5, 1), 1, 0, st);
      chk("perf_sat", 64'(sb.o_stall_cycles), 64'hFFFF);
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end
endmodule
